warp_dispatcher: RTL and testbench
==================================

Name: warp_dispatcher

Overview:
- Sits directly downstream of the warp scheduler.
- Accepts kernel descriptors (warp_id, start_pc, thread_count) and installs them in a per-warp table.
- Issues ready warps round-robin to the SIMD fetch stage over a valid/ready port.
- Retires or re-arms warps on update from the SIMD cores, and reports the free-warp mask back upstream for warp-ID allocation.

Parameters:
- NUM_WARPS, 16: warp table entries; one per warp ID.
- WARP_ID_W, 4: warp ID width; equals log2(NUM_WARPS).
- LOG2_THREAD_COUNT, 3: thread_count field width.
- THREAD_COUNT, 8: lanes per warp; width of the thread mask.
- PC_W, 32: program counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- kin_valid  in  1  kernel descriptor valid.
- kin_ready  out  1  dispatcher can accept a descriptor; equals |open_warp_ids.
- kin_warp_id  in  WARP_ID_W  target table entry.
- kin_start_pc  in  PC_W  first PC for the warp.
- kin_thread_count  in  LOG2_THREAD_COUNT  active threads, 1..7; 0 is illegal.
- open_warp_ids  out  NUM_WARPS  bit i = 1 when entry i is FREE; registered.
- iss_valid  out  1  issue register holds a warp.
- iss_ready  in  1  fetch stage accepts the issue.
- iss_warp_id  out  WARP_ID_W  issued warp.
- iss_pc  out  PC_W  PC to fetch.
- iss_thread_mask  out  THREAD_COUNT  the low thread_count bits set.
- upd_valid  in  1  warp update from the SIMD core.
- upd_warp_id  in  WARP_ID_W  warp being updated.
- upd_next_pc  in  PC_W  PC for the warp's next issue.
- upd_done  in  1  warp finished; free the entry.
- active_warps  out  WARP_ID_W+1  count of non-FREE entries; registered.
- err_pulse  out  1  one-cycle pulse on a rejected descriptor or update.

Behaviour:
- Per-entry state: FREE, READY, INFLIGHT. Each entry also stores pc (PC_W) and count (LOG2_THREAD_COUNT).

Reset (asynchronous, takes effect immediately, including mid-operation):
- All entries FREE; pc and count = 0.
- rr_ptr = 0.
- iss_valid = 0; iss_warp_id, iss_pc, iss_thread_mask = 0.
- open_warp_ids = all ones; active_warps = 0; err_pulse = 0; kin_ready = 1 once reset is released.
- Any in-flight issue is dropped with no completion.

Install (kin_valid && kin_ready at edge N):
- If entry[kin_warp_id] is FREE and kin_thread_count != 0: state becomes READY with pc = kin_start_pc and count = kin_thread_count, visible after edge N.
- Otherwise the descriptor is discarded and err_pulse = 1 in cycle N+1.
- kin_valid while kin_ready = 0 is not accepted; there is no error.

Issue register:
- Loads at any edge where !iss_valid || iss_ready.
- Selection: the first READY entry scanning upward from rr_ptr, modulo NUM_WARPS.
- On load:
  - iss_valid = 1; fields taken from the entry.
  - Entry moves READY -> INFLIGHT.
  - rr_ptr = selected id + 1, wrapping 15 -> 0.
- No READY entry: iss_valid = 0.
- While iss_valid && !iss_ready, all iss_* outputs are held stable.
- Back-to-back issue: handshake and reload happen on the same edge.
- Latency: a warp installed at edge N appears on iss_valid after edge N+1 if the register is empty.
- iss_thread_mask = (1 << count) - 1. Example: count 5 -> 8'b0001_1111.

Update (upd_valid at edge N):
- Legal only when the entry is INFLIGHT and not currently held in the issue register (not iss_valid with iss_warp_id == upd_warp_id).
- upd_done = 1: entry becomes FREE.
- upd_done = 0: entry becomes READY with pc = upd_next_pc.
- Illegal update: ignored, err_pulse = 1 in cycle N+1.

Simultaneous events:
- Install and update to different ids in the same cycle: both apply.
- Install targeting an id freed by upd_done in the same cycle: rejected with err, because the pre-edge state is used.
- An entry re-armed to READY by an update is first eligible for selection on the following edge.
- Install, update and issue load may all occur on one edge.
- Both errors in one cycle produce a single err_pulse.

Status outputs:
- open_warp_ids and active_warps reflect the state after each edge.
- active_warps ranges 0..16. All 16 allocated: kin_ready = 0.

Test Plan:
- Reset, then install id 3 (pc 0x100, count 5) with iss_ready = 1 -> after edge N+1: iss_valid = 1, iss_warp_id = 3, iss_pc = 0x100, mask 0x1F; open_warp_ids = 0xFFF7; active_warps = 1.
- Install ids 0, 1, 2; hold iss_ready = 0 for 3 cycles, then 1 -> id 0 is held stable, then issues 0, 1, 2 back-to-back; rr_ptr ends at 3.
- Issue id 3, then update id 3 with next_pc 0x104 and done = 0 -> re-issues pc 0x104. A second update with done = 1 -> id 3 FREE, active_warps = 0.
- Install id 5 twice; separately, install id 6 with count 0 -> err_pulse once per bad request; table unchanged for the rejected requests.
- Fill all 16 entries -> kin_ready = 0. A done update on id 7 -> kin_ready = 1 and bit 7 of open_warp_ids set after the edge. A same-cycle install to id 7 is rejected.
- Assert rst while iss_valid = 1 with warps INFLIGHT -> iss_valid = 0 and open_warp_ids = 0xFFFF immediately; after release, an update to a former warp produces err_pulse.

Source files
------------

// File: rtl/warp_dispatcher.sv
// Warp dispatcher: installs kernel descriptors into a per-warp table, issues READY warps
// round-robin to SIMD fetch, and retires or re-arms them on core updates.
module warp_dispatcher #(
  parameter int NUM_WARPS         = 16,
  parameter int WARP_ID_W         = 4,
  parameter int LOG2_THREAD_COUNT = 3,
  parameter int THREAD_COUNT      = 8,
  parameter int PC_W              = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         kin_valid,
  output logic                         kin_ready,
  input  logic [WARP_ID_W-1:0]         kin_warp_id,
  input  logic [PC_W-1:0]              kin_start_pc,
  input  logic [LOG2_THREAD_COUNT-1:0] kin_thread_count,
  output logic [NUM_WARPS-1:0]         open_warp_ids,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [WARP_ID_W-1:0]         iss_warp_id,
  output logic [PC_W-1:0]              iss_pc,
  output logic [THREAD_COUNT-1:0]      iss_thread_mask,
  input  logic                         upd_valid,
  input  logic [WARP_ID_W-1:0]         upd_warp_id,
  input  logic [PC_W-1:0]              upd_next_pc,
  input  logic                         upd_done,
  output logic [WARP_ID_W:0]           active_warps,
  output logic                         err_pulse
);

  typedef enum logic [1:0] {FREE = 2'd0, READY = 2'd1, INFLIGHT = 2'd2} warp_state_t;

  warp_state_t                  state_q [NUM_WARPS];
  warp_state_t                  state_d [NUM_WARPS];
  logic [PC_W-1:0]              pc_q    [NUM_WARPS];
  logic [PC_W-1:0]              pc_d    [NUM_WARPS];
  logic [LOG2_THREAD_COUNT-1:0] count_q [NUM_WARPS];
  logic [LOG2_THREAD_COUNT-1:0] count_d [NUM_WARPS];

  logic [WARP_ID_W-1:0]    rr_ptr;
  logic [WARP_ID_W-1:0]    sel_id;
  logic                    sel_found;
  logic [THREAD_COUNT-1:0] sel_mask;
  logic                    load;
  logic                    install_ok;
  logic                    install_err;
  logic                    upd_ok;
  logic                    upd_err;
  logic [NUM_WARPS-1:0]    open_d;
  logic [WARP_ID_W:0]      active_d;

  assign kin_ready = |open_warp_ids;
  assign load      = !iss_valid || iss_ready;

  // All legality checks use the pre-edge table, so a same-cycle free does not open an entry
  assign install_ok  = kin_valid && kin_ready && (state_q[kin_warp_id] == FREE) &&
                       (kin_thread_count != '0);
  assign install_err = kin_valid && kin_ready && !install_ok;
  assign upd_ok      = upd_valid && (state_q[upd_warp_id] == INFLIGHT) &&
                       !(iss_valid && (iss_warp_id == upd_warp_id));
  assign upd_err     = upd_valid && !upd_ok;

  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (!sel_found && (state_q[rr_ptr + WARP_ID_W'(i)] == READY)) begin
        sel_found = 1'b1;
        sel_id    = rr_ptr + WARP_ID_W'(i);
      end
    end
    sel_mask = (THREAD_COUNT'(1) << count_q[sel_id]) - THREAD_COUNT'(1);
  end

  // Install, update and issue never touch the same entry: they require FREE, INFLIGHT and READY
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    if (install_ok) begin
      state_d[kin_warp_id] = READY;
      pc_d[kin_warp_id]    = kin_start_pc;
      count_d[kin_warp_id] = kin_thread_count;
    end
    if (upd_ok) begin
      if (upd_done) begin
        state_d[upd_warp_id] = FREE;
      end else begin
        state_d[upd_warp_id] = READY;
        pc_d[upd_warp_id]    = upd_next_pc;
      end
    end
    if (load && sel_found) begin
      state_d[sel_id] = INFLIGHT;
    end
  end

  always_comb begin
    open_d   = '0;
    active_d = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      open_d[i] = (state_d[i] == FREE);
      active_d  = active_d + {{WARP_ID_W{1'b0}}, (state_d[i] != FREE)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        state_q[i] <= FREE;
        pc_q[i]    <= '0;
        count_q[i] <= '0;
      end
      open_warp_ids <= '1;
      active_warps  <= '0;
      err_pulse     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      count_q       <= count_d;
      open_warp_ids <= open_d;
      active_warps  <= active_d;
      err_pulse     <= install_err || upd_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr          <= '0;
      iss_valid       <= 1'b0;
      iss_warp_id     <= '0;
      iss_pc          <= '0;
      iss_thread_mask <= '0;
    end else if (load) begin
      iss_valid <= sel_found;
      if (sel_found) begin
        iss_warp_id     <= sel_id;
        iss_pc          <= pc_q[sel_id];
        iss_thread_mask <= sel_mask;
        rr_ptr          <= sel_id + WARP_ID_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_warp_dispatcher.sv
// Directed self-checking bench for warp_dispatcher: install, issue, update, error,
// full-table and mid-operation reset scenarios with hand-computed expectations.
module tb_warp_dispatcher;

  localparam int NUM_WARPS = 16;
  localparam int WARP_ID_W = 4;
  localparam int LTC       = 3;
  localparam int TC        = 8;
  localparam int PC_W      = 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 kin_valid = 1'b0;
  logic                 kin_ready;
  logic [WARP_ID_W-1:0] kin_warp_id = '0;
  logic [PC_W-1:0]      kin_start_pc = '0;
  logic [LTC-1:0]       kin_thread_count = '0;
  logic [NUM_WARPS-1:0] open_warp_ids;
  logic                 iss_valid;
  logic                 iss_ready = 1'b0;
  logic [WARP_ID_W-1:0] iss_warp_id;
  logic [PC_W-1:0]      iss_pc;
  logic [TC-1:0]        iss_thread_mask;
  logic                 upd_valid = 1'b0;
  logic [WARP_ID_W-1:0] upd_warp_id = '0;
  logic [PC_W-1:0]      upd_next_pc = '0;
  logic                 upd_done = 1'b0;
  logic [WARP_ID_W:0]   active_warps;
  logic                 err_pulse;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  warp_dispatcher dut (
    .clk(clk), .rst(rst),
    .kin_valid(kin_valid), .kin_ready(kin_ready), .kin_warp_id(kin_warp_id),
    .kin_start_pc(kin_start_pc), .kin_thread_count(kin_thread_count),
    .open_warp_ids(open_warp_ids),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_warp_id(iss_warp_id),
    .iss_pc(iss_pc), .iss_thread_mask(iss_thread_mask),
    .upd_valid(upd_valid), .upd_warp_id(upd_warp_id), .upd_next_pc(upd_next_pc),
    .upd_done(upd_done), .active_warps(active_warps), .err_pulse(err_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_kin(input logic v, input int id, input int pc, input int cnt);
    kin_valid        = v;
    kin_warp_id      = WARP_ID_W'(id);
    kin_start_pc     = PC_W'(pc);
    kin_thread_count = LTC'(cnt);
  endtask

  task automatic drive_upd(input logic v, input int id, input int pc, input logic done);
    upd_valid   = v;
    upd_warp_id = WARP_ID_W'(id);
    upd_next_pc = PC_W'(pc);
    upd_done    = done;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_iss_valid: got %b expected 0", iss_valid); end
    checks++; if (open_warp_ids !== 16'hFFFF) begin errors++; $display("[TB] FAIL reset_open: got %h expected ffff", open_warp_ids); end
    checks++; if (active_warps !== 5'd0) begin errors++; $display("[TB] FAIL reset_active: got %0d expected 0", active_warps); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err_pulse); end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (kin_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_kin_ready: got %b expected 1", kin_ready); end
    checks++; if (iss_pc !== 32'h0 || iss_thread_mask !== 8'h00) begin errors++; $display("[TB] FAIL reset_iss_fields: got pc=%h mask=%h expected 0/0", iss_pc, iss_thread_mask); end
  endtask

  task automatic test_install_issue();
    iss_ready = 1'b1;
    drive_kin(1'b1, 3, 'h100, 5);
    tick();
    drive_kin(1'b0, 0, 0, 0);
    checks++; if (open_warp_ids !== 16'hFFF7 || active_warps !== 5'd1) begin errors++; $display("[TB] FAIL install_status: got open=%h active=%0d expected fff7/1", open_warp_ids, active_warps); end
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("[TB] FAIL install_latency: got iss_valid=%b expected 0", iss_valid); end
    tick();
    checks++; if (iss_valid !== 1'b1 || iss_warp_id !== 4'd3 || iss_pc !== 32'h100 || iss_thread_mask !== 8'h1F) begin errors++; $display("[TB] FAIL first_issue: got v=%b id=%0d pc=%h mask=%h expected 1/3/100/1f", iss_valid, iss_warp_id, iss_pc, iss_thread_mask); end
    tick();
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("[TB] FAIL issue_drain: got %b expected 0", iss_valid); end
    drive_upd(1'b1, 3, 'h104, 1'b0);
    tick();
    drive_upd(1'b0, 0, 0, 1'b0);
    checks++; if (err_pulse !== 1'b0 || iss_valid !== 1'b0) begin errors++; $display("[TB] FAIL rearm_edge: got err=%b v=%b expected 0/0", err_pulse, iss_valid); end
    tick();
    checks++; if (iss_valid !== 1'b1 || iss_warp_id !== 4'd3 || iss_pc !== 32'h104) begin errors++; $display("[TB] FAIL reissue: got v=%b id=%0d pc=%h expected 1/3/104", iss_valid, iss_warp_id, iss_pc); end
    tick();
    drive_upd(1'b1, 3, 0, 1'b1);
    tick();
    drive_upd(1'b0, 0, 0, 1'b0);
    checks++; if (active_warps !== 5'd0 || open_warp_ids !== 16'hFFFF || err_pulse !== 1'b0) begin errors++; $display("[TB] FAIL retire: got active=%0d open=%h err=%b expected 0/ffff/0", active_warps, open_warp_ids, err_pulse); end
  endtask

  task automatic test_back_to_back();
    iss_ready = 1'b0;
    drive_kin(1'b1, 0, 'h200, 1);
    tick();
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_empty: got %b expected 0", iss_valid); end
    drive_kin(1'b1, 1, 'h300, 7);
    tick();
    drive_kin(1'b1, 2, 'h400, 3);
    tick();
    drive_kin(1'b0, 0, 0, 0);
    checks++; if (active_warps !== 5'd3) begin errors++; $display("[TB] FAIL b2b_active: got %0d expected 3", active_warps); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (iss_valid !== 1'b1 || iss_warp_id !== 4'd0 || iss_pc !== 32'h200 || iss_thread_mask !== 8'h01) begin errors++; $display("[TB] FAIL hold_%0d: got v=%b id=%0d pc=%h mask=%h expected 1/0/200/01", i, iss_valid, iss_warp_id, iss_pc, iss_thread_mask); end
      tick();
    end
    iss_ready = 1'b1;
    tick();
    checks++; if (iss_valid !== 1'b1 || iss_warp_id !== 4'd1 || iss_pc !== 32'h300 || iss_thread_mask !== 8'h7F) begin errors++; $display("[TB] FAIL b2b_id1: got v=%b id=%0d pc=%h mask=%h expected 1/1/300/7f", iss_valid, iss_warp_id, iss_pc, iss_thread_mask); end
    tick();
    checks++; if (iss_valid !== 1'b1 || iss_warp_id !== 4'd2 || iss_pc !== 32'h400 || iss_thread_mask !== 8'h07) begin errors++; $display("[TB] FAIL b2b_id2: got v=%b id=%0d pc=%h mask=%h expected 1/2/400/07", iss_valid, iss_warp_id, iss_pc, iss_thread_mask); end
    tick();
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got %b expected 0", iss_valid); end
    for (int i = 0; i < 3; i++) begin
      drive_upd(1'b1, i, 0, 1'b1);
      tick();
    end
    drive_upd(1'b0, 0, 0, 1'b0);
    checks++; if (active_warps !== 5'd0 || open_warp_ids !== 16'hFFFF) begin errors++; $display("[TB] FAIL b2b_retire: got active=%0d open=%h expected 0/ffff", active_warps, open_warp_ids); end
  endtask

  task automatic test_errors();
    iss_ready = 1'b0;
    drive_kin(1'b1, 5, 'h500, 2);
    tick();
    checks++; if (err_pulse !== 1'b0 || open_warp_ids !== 16'hFFDF) begin errors++; $display("[TB] FAIL err_first_install: got err=%b open=%h expected 0/ffdf", err_pulse, open_warp_ids); end
    drive_kin(1'b1, 5, 'h555, 4);
    tick();
    checks++; if (err_pulse !== 1'b1 || active_warps !== 5'd1) begin errors++; $display("[TB] FAIL err_dup_install: got err=%b active=%0d expected 1/1", err_pulse, active_warps); end
    checks++; if (iss_valid !== 1'b1 || iss_warp_id !== 4'd5 || iss_pc !== 32'h500 || iss_thread_mask !== 8'h03) begin errors++; $display("[TB] FAIL err_table_kept: got v=%b id=%0d pc=%h mask=%h expected 1/5/500/03", iss_valid, iss_warp_id, iss_pc, iss_thread_mask); end
    drive_kin(1'b0, 0, 0, 0);
    tick();
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("[TB] FAIL err_one_cycle: got %b expected 0", err_pulse); end
    drive_kin(1'b1, 6, 'h600, 0);
    tick();
    drive_kin(1'b0, 0, 0, 0);
    checks++; if (err_pulse !== 1'b1 || open_warp_ids !== 16'hFFDF || active_warps !== 5'd1) begin errors++; $display("[TB] FAIL err_zero_count: got err=%b open=%h active=%0d expected 1/ffdf/1", err_pulse, open_warp_ids, active_warps); end
    drive_upd(1'b1, 5, 'h999, 1'b0);
    tick();
    drive_upd(1'b0, 0, 0, 1'b0);
    checks++; if (err_pulse !== 1'b1 || iss_pc !== 32'h500) begin errors++; $display("[TB] FAIL err_upd_held: got err=%b pc=%h expected 1/500", err_pulse, iss_pc); end
    iss_ready = 1'b1;
    tick();
    checks++; if (err_pulse !== 1'b0 || iss_valid !== 1'b0) begin errors++; $display("[TB] FAIL err_release: got err=%b v=%b expected 0/0", err_pulse, iss_valid); end
    drive_upd(1'b1, 5, 0, 1'b1);
    tick();
    drive_upd(1'b0, 0, 0, 1'b0);
    checks++; if (active_warps !== 5'd0 || err_pulse !== 1'b0) begin errors++; $display("[TB] FAIL err_cleanup: got active=%0d err=%b expected 0/0", active_warps, err_pulse); end
  endtask

  task automatic test_full_table();
    iss_ready = 1'b1;
    for (int k = 0; k < NUM_WARPS; k++) begin
      drive_kin(1'b1, k, 'h1000 + 4 * k, (k % 7) + 1);
      tick();
      if (k >= 1) begin
        checks++; if (iss_valid !== 1'b1 || iss_warp_id !== WARP_ID_W'(k - 1) || iss_pc !== PC_W'('h1000 + 4 * (k - 1))) begin errors++; $display("[TB] FAIL fill_issue_%0d: got v=%b id=%0d pc=%h expected 1/%0d/%h", k, iss_valid, iss_warp_id, iss_pc, k - 1, 'h1000 + 4 * (k - 1)); end
      end
    end
    drive_kin(1'b0, 0, 0, 0);
    checks++; if (kin_ready !== 1'b0 || active_warps !== 5'd16 || open_warp_ids !== 16'h0000) begin errors++; $display("[TB] FAIL full_status: got ready=%b active=%0d open=%h expected 0/16/0000", kin_ready, active_warps, open_warp_ids); end
    tick();
    tick();
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_drain: got %b expected 0", iss_valid); end
    drive_upd(1'b1, 7, 0, 1'b1);
    drive_kin(1'b1, 7, 'h777, 1);
    tick();
    checks++; if (kin_ready !== 1'b1 || open_warp_ids !== 16'h0080 || active_warps !== 5'd15 || err_pulse !== 1'b0) begin errors++; $display("[TB] FAIL full_free7: got ready=%b open=%h active=%0d err=%b expected 1/0080/15/0", kin_ready, open_warp_ids, active_warps, err_pulse); end
    drive_upd(1'b1, 8, 0, 1'b1);
    drive_kin(1'b1, 8, 'h888, 1);
    tick();
    drive_upd(1'b0, 0, 0, 1'b0);
    drive_kin(1'b0, 0, 0, 0);
    checks++; if (err_pulse !== 1'b1 || open_warp_ids !== 16'h0180 || active_warps !== 5'd14) begin errors++; $display("[TB] FAIL same_cycle_reinstall: got err=%b open=%h active=%0d expected 1/0180/14", err_pulse, open_warp_ids, active_warps); end
  endtask

  task automatic test_reset_midop();
    iss_ready = 1'b0;
    drive_kin(1'b1, 7, 'h700, 2);
    tick();
    drive_kin(1'b0, 0, 0, 0);
    tick();
    checks++; if (iss_valid !== 1'b1 || iss_warp_id !== 4'd7 || iss_pc !== 32'h700) begin errors++; $display("[TB] FAIL pre_reset_issue: got v=%b id=%0d pc=%h expected 1/7/700", iss_valid, iss_warp_id, iss_pc); end
    #1 rst = 1'b1;
    #1;
    checks++; if (iss_valid !== 1'b0 || open_warp_ids !== 16'hFFFF || active_warps !== 5'd0 || iss_warp_id !== 4'd0) begin errors++; $display("[TB] FAIL async_reset: got v=%b open=%h active=%0d id=%0d expected 0/ffff/0/0", iss_valid, open_warp_ids, active_warps, iss_warp_id); end
    #2 rst = 1'b0;
    drive_upd(1'b1, 3, 'h30, 1'b0);
    tick();
    drive_upd(1'b0, 0, 0, 1'b0);
    checks++; if (err_pulse !== 1'b1 || kin_ready !== 1'b1) begin errors++; $display("[TB] FAIL stale_update: got err=%b ready=%b expected 1/1", err_pulse, kin_ready); end
    tick();
    checks++; if (err_pulse !== 1'b0 || active_warps !== 5'd0) begin errors++; $display("[TB] FAIL post_reset_idle: got err=%b active=%0d expected 0/0", err_pulse, active_warps); end
  endtask

  initial begin
    test_reset();
    test_install_issue();
    test_back_to_back();
    test_errors();
    test_full_table();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
